mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, meaning the word address width, matching the 13-bit operand field.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the word width (3-bit opcode + 13-bit operand).
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 1, legal range 0..15, meaning the wait states inserted before completion.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port rd_mem, input, 1 bit: read request strobe from the controller.
REQ-007 The block SHALL have port wr_mem, input, 1 bit: write request strobe from the controller.
REQ-008 The block SHALL have port addr, input, ADDR_W bits: word address.
REQ-009 The block SHALL have port wdata, input, DATA_W bits: write data (accumulator value).
REQ-010 The block SHALL have port rdata, output, DATA_W bits: read data, valid when ready=1 and the completed access was a read.
REQ-011 The block SHALL have port ready, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a request is accepted and not yet completed.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse when rd_mem and wr_mem are both sampled high in IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-015 In IDLE with exactly one of rd_mem/wr_mem high, the block SHALL latch the request type, addr and wdata, set busy=1, and go to WAIT (WAIT_CYCLES>0) or DONE (WAIT_CYCLES=0).
REQ-016 In IDLE with both strobes high, the block SHALL pulse err for one cycle, perform no access, and stay in IDLE.
REQ-017 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle; at 0 the FSM SHALL go to DONE.
REQ-018 In DONE, the block SHALL perform the latched write or read on the array, assert ready for exactly that cycle, clear busy, and return to IDLE.
REQ-019 Latency from the accepting edge to ready SHALL be WAIT_CYCLES+1 cycles.
REQ-020 rdata SHALL update only on completed reads and SHALL hold its value otherwise, including across writes.
REQ-021 Strobe, addr and wdata changes after acceptance SHALL be ignored until return to IDLE.
REQ-022 A strobe still high in the cycle after ready SHALL be accepted as a new request (back-to-back); the requester drops strobes on ready to prevent this.
REQ-023 A write followed by a read of the same address SHALL return the newly written value.
REQ-024 Addresses SHALL wrap naturally within 2^ADDR_W words; no out-of-range condition exists.

Reset
REQ-025 On rst_n=0, state SHALL be IDLE immediately, counter=0, ready=0, busy=0, err=0, rdata=0.
REQ-026 Reset asserted during WAIT SHALL discard the pending request; a pending write SHALL NOT modify the array.
REQ-027 Array contents SHALL NOT be cleared by reset.

Structure
REQ-028 ADDR_W/DATA_W defaults, opcode constants (LDA..HLT) and the FSM state encoding SHALL reside in the shared cpu package.
REQ-029 The storage SHALL be one sub-module, mem_array: single-port synchronous RAM with write enable and registered read.

Verification
REQ-030 WAIT_CYCLES=1: wr_mem, addr=0x0005, wdata=0x1234 -> busy high 2 cycles, ready pulse on 2nd edge; then rd_mem addr=0x0005 -> rdata=0x1234 with ready.
REQ-031 rd_mem and wr_mem high together in IDLE -> err pulse for 1 cycle, busy=0, ready=0, array location unchanged.
REQ-032 WAIT_CYCLES=0: rd_mem held high for 3 accepted reads of addr=0x1FFF -> ready at cycles 1, 3, 5 after first edge, rdata stable between pulses.
REQ-033 WAIT_CYCLES=3: write 0xBEEF to addr=0x0010, rst_n low at cycle 2 -> outputs zero immediately; read of 0x0010 after reset returns the prior value, not 0xBEEF.
REQ-034 Accepted read of addr=0x0001, addr changed to 0x0002 during WAIT -> returned rdata is the contents of 0x0001.
REQ-035 Write then read of addr=0x0000 and addr=0x1FFF -> both return written values, no aliasing.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared CPU definitions used by the memory responder and its bus interface.
// Contents:
//    ADDR_W_DEF / DATA_W_DEF : default word-address and word widths.
//                              A word is a 3-bit opcode plus a 13-bit operand.
//    opcode_e                : instruction opcodes, LDA through HLT.
//    state_e                 : responder FSM state encoding.
//    word_opcode/word_operand: helpers that split an instruction word.
package mem_responder_pkg;

   localparam int ADDR_W_DEF = 13;
   localparam int DATA_W_DEF = 16;
   localparam int OPCODE_W   = 3;

   typedef enum logic [OPCODE_W-1:0] {
      LDA = 3'd0,
      STA = 3'd1,
      ADD = 3'd2,
      SUB = 3'd3,
      JMP = 3'd4,
      JZ  = 3'd5,
      OUT = 3'd6,
      HLT = 3'd7
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   // Opcode field of an instruction word.
   function automatic opcode_e word_opcode(input logic [DATA_W_DEF-1:0] word);
      return opcode_e'(word[DATA_W_DEF-1 -: OPCODE_W]);
   endfunction

   // Operand (address) field of an instruction word.
   function automatic logic [ADDR_W_DEF-1:0] word_operand(input logic [DATA_W_DEF-1:0] word);
      return word[ADDR_W_DEF-1:0];
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if
// Request/response bus between the CPU controller and the memory responder.
// Signals:
//    rd_mem, wr_mem : request strobes from the controller
//    addr, wdata    : word address and write data from the controller
//    rdata          : read data, meaningful alongside ready after a read
//    ready          : one-cycle completion pulse
//    busy           : a request is accepted and not yet completed
//    err            : one-cycle pulse when both strobes arrive together
// Modports: master (controller side), slave (responder side).
interface mem_responder_if #(
   parameter int ADDR_W = mem_responder_pkg::ADDR_W_DEF,
   parameter int DATA_W = mem_responder_pkg::DATA_W_DEF
);

   logic              rd_mem;
   logic              wr_mem;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              busy;
   logic              err;

   modport master (
      output rd_mem, wr_mem, addr, wdata,
      input  rdata, ready, busy, err
   );

   modport slave (
      input  rd_mem, wr_mem, addr, wdata,
      output rdata, ready, busy, err
   );

endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_array
// Single-port synchronous RAM with write enable and registered read.
// Ports:
//    clk   : clock, rising edge
//    rst_n : asynchronous active-low reset; clears only the read register
//    en    : access enable for this cycle
//    we    : 1 = write wdata to addr, 0 = read addr into rdata
//    addr  : word address
//    wdata : write data
//    rdata : registered read data; changes only on enabled reads
module mem_array #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // Storage has no reset so its contents survive a responder reset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[addr] <= wdata;
      end
   end

   // Read register holds its value through writes and idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Accepts one read or write request at a time from the CPU controller,
// inserts WAIT_CYCLES wait states and completes the access against mem_array.
// Parameters:
//    ADDR_W      : word address width
//    DATA_W      : word width
//    WAIT_CYCLES : wait states before completion (0..15)
// Ports:
//    clk   : clock, rising edge
//    rst_n : asynchronous active-low reset
//    bus   : mem_responder_if slave (strobes, addr, wdata in; rdata, ready, busy, err out)
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   mem_responder_if.slave bus
);

   // WAIT exits when the counter reaches zero, so loading WAIT_CYCLES-1
   // yields exactly WAIT_CYCLES cycles spent in WAIT.
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_e            state;
   logic [3:0]        cnt;
   logic              ready_q;
   logic              busy_q;
   logic              err_q;
   logic              lat_write;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] array_rdata;
   logic              array_en;

   // Request FSM. Everything the controller sees is registered here; the
   // request is latched on acceptance so later bus changes cannot disturb it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.rd_mem && bus.wr_mem) begin
                  err_q <= 1'b1;
               end else if (bus.rd_mem || bus.wr_mem) begin
                  lat_write <= bus.wr_mem;
                  lat_addr  <= bus.addr;
                  lat_wdata <= bus.wdata;
                  busy_q    <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state <= DONE;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_LOAD;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The array access happens on the edge that leaves DONE, the same edge
   // that raises ready, so read data and ready appear together.
   assign array_en = (state == DONE);

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_array (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (array_en),
      .we    (lat_write),
      .addr  (lat_addr),
      .wdata (lat_wdata),
      .rdata (array_rdata)
   );

   assign bus.rdata = array_rdata;
   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Directed bench for mem_responder. Three instances with WAIT_CYCLES of 0, 1
// and 3 share one set of request drivers; sel chooses which instance sees the
// strobes and whose outputs are observed.
module tb_mem_responder;
   import mem_responder_pkg::*;

   logic        clk;
   logic        rst_n;
   int          sel;
   logic        tb_rd;
   logic        tb_wr;
   logic [12:0] tb_addr;
   logic [15:0] tb_wdata;
   logic        obs_ready;
   logic        obs_busy;
   logic        obs_err;
   logic [15:0] obs_rdata;
   int          vectors;
   int          miscompares;
   int          lat;

   mem_responder_if #(.ADDR_W(13), .DATA_W(16)) if0 ();
   mem_responder_if #(.ADDR_W(13), .DATA_W(16)) if1 ();
   mem_responder_if #(.ADDR_W(13), .DATA_W(16)) if3 ();

   mem_responder #(.ADDR_W(13), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   mem_responder #(.ADDR_W(13), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   mem_responder #(.ADDR_W(13), .DATA_W(16), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

   assign if0.rd_mem = tb_rd & (sel == 0);
   assign if0.wr_mem = tb_wr & (sel == 0);
   assign if0.addr   = tb_addr;
   assign if0.wdata  = tb_wdata;
   assign if1.rd_mem = tb_rd & (sel == 1);
   assign if1.wr_mem = tb_wr & (sel == 1);
   assign if1.addr   = tb_addr;
   assign if1.wdata  = tb_wdata;
   assign if3.rd_mem = tb_rd & (sel == 2);
   assign if3.wr_mem = tb_wr & (sel == 2);
   assign if3.addr   = tb_addr;
   assign if3.wdata  = tb_wdata;

   always_comb begin
      obs_ready = if0.ready;
      obs_busy  = if0.busy;
      obs_err   = if0.err;
      obs_rdata = if0.rdata;
      case (sel)
         1: begin
            obs_ready = if1.ready;
            obs_busy  = if1.busy;
            obs_err   = if1.err;
            obs_rdata = if1.rdata;
         end
         2: begin
            obs_ready = if3.ready;
            obs_busy  = if3.busy;
            obs_err   = if3.err;
            obs_rdata = if3.rdata;
         end
         default: ;
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request, drops the strobe after acceptance and waits for
   // ready. lat receives the edges from acceptance to ready.
   task automatic do_access(input logic is_wr, input logic [12:0] a, input logic [15:0] d);
      tb_rd    = !is_wr;
      tb_wr    = is_wr;
      tb_addr  = a;
      tb_wdata = d;
      step();
      tb_rd = 1'b0;
      tb_wr = 1'b0;
      lat   = 0;
      while (!obs_ready && lat < 20) begin
         step();
         lat++;
      end
      vectors++;
      if (obs_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL access timeout sel=%0d addr=%h: ready got %b want 1", sel, a, obs_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tb_rd = 1'b0; tb_wr = 1'b0; tb_addr = '0; tb_wdata = '0;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         vectors++;
         if ({obs_ready, obs_busy, obs_err, obs_rdata} !== 19'd0) begin
            miscompares++;
            $display("[TB] FAIL reset outputs sel=%0d: got r%b b%b e%b d%h want all 0", s, obs_ready, obs_busy, obs_err, obs_rdata);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_write_read();
      sel = 1;
      tb_wr = 1'b1; tb_addr = 13'h0005; tb_wdata = 16'h1234;
      step();
      vectors++; if (obs_busy !== 1'b1 || obs_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL wr edge0: got b%b r%b want b1 r0", obs_busy, obs_ready); end
      tb_wr = 1'b0; tb_addr = 13'h0007; tb_wdata = 16'h0000;
      step();
      vectors++; if (obs_busy !== 1'b1 || obs_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL wr edge1: got b%b r%b want b1 r0", obs_busy, obs_ready); end
      step();
      vectors++; if (obs_busy !== 1'b0 || obs_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wr edge2: got b%b r%b want b0 r1", obs_busy, obs_ready); end
      step();
      vectors++; if (obs_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ready pulse width: got %b want 0", obs_ready); end
      do_access(1'b0, 13'h0005, 16'h0000);
      vectors++; if (obs_rdata !== 16'h1234) begin miscompares++; $display("[TB] FAIL read 0005: got %h want 1234", obs_rdata); end
      vectors++; if (lat !== 2) begin miscompares++; $display("[TB] FAIL latency wc1: got %0d want 2", lat); end
      do_access(1'b1, 13'h0006, 16'h5555);
      vectors++; if (obs_rdata !== 16'h1234) begin miscompares++; $display("[TB] FAIL rdata hold across write: got %h want 1234", obs_rdata); end
   endtask

   task automatic test_collision();
      sel = 1;
      tb_rd = 1'b1; tb_wr = 1'b1; tb_addr = 13'h0005; tb_wdata = 16'hFFFF;
      step();
      vectors++; if (obs_err !== 1'b1 || obs_busy !== 1'b0 || obs_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL collision: got e%b b%b r%b want e1 b0 r0", obs_err, obs_busy, obs_ready); end
      tb_rd = 1'b0; tb_wr = 1'b0;
      step();
      vectors++; if (obs_err !== 1'b0 || obs_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL collision after: got e%b b%b want e0 b0", obs_err, obs_busy); end
      do_access(1'b0, 13'h0005, 16'h0000);
      vectors++; if (obs_rdata !== 16'h1234) begin miscompares++; $display("[TB] FAIL collision left array: got %h want 1234", obs_rdata); end
   endtask

   task automatic test_back_to_back();
      sel = 0;
      do_access(1'b1, 13'h1FFF, 16'hABCD);
      vectors++; if (lat !== 1) begin miscompares++; $display("[TB] FAIL latency wc0: got %0d want 1", lat); end
      tb_rd = 1'b1; tb_addr = 13'h1FFF;
      for (int i = 0; i < 6; i++) begin
         step();
         vectors++;
         if (obs_ready !== ((i % 2) == 1)) begin
            miscompares++;
            $display("[TB] FAIL b2b ready cycle %0d: got %b want %b", i, obs_ready, ((i % 2) == 1));
         end
         vectors++;
         if (obs_rdata !== ((i == 0) ? 16'h0000 : 16'hABCD)) begin
            miscompares++;
            $display("[TB] FAIL b2b rdata cycle %0d: got %h want %h", i, obs_rdata, ((i == 0) ? 16'h0000 : 16'hABCD));
         end
      end
      tb_rd = 1'b0;
      step();
      vectors++; if (obs_ready !== 1'b0 || obs_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b stop: got r%b b%b want r0 b0", obs_ready, obs_busy); end
   endtask

   task automatic test_no_alias();
      sel = 0;
      do_access(1'b1, 13'h0000, 16'h1111);
      do_access(1'b1, 13'h1FFF, 16'h2222);
      do_access(1'b0, 13'h0000, 16'h0000);
      vectors++; if (obs_rdata !== 16'h1111) begin miscompares++; $display("[TB] FAIL alias 0000: got %h want 1111", obs_rdata); end
      do_access(1'b0, 13'h1FFF, 16'h0000);
      vectors++; if (obs_rdata !== 16'h2222) begin miscompares++; $display("[TB] FAIL alias 1FFF: got %h want 2222", obs_rdata); end
   endtask

   task automatic test_addr_ignored();
      sel = 1;
      do_access(1'b1, 13'h0001, 16'hAAAA);
      do_access(1'b1, 13'h0002, 16'hBBBB);
      tb_rd = 1'b1; tb_addr = 13'h0001;
      step();
      tb_rd = 1'b0; tb_addr = 13'h0002;
      step();
      step();
      vectors++; if (obs_ready !== 1'b1 || obs_rdata !== 16'hAAAA) begin miscompares++; $display("[TB] FAIL addr change in wait: got r%b %h want r1 aaaa", obs_ready, obs_rdata); end
   endtask

   task automatic test_reset_in_wait();
      sel = 2;
      do_access(1'b1, 13'h0010, 16'h7777);
      vectors++; if (lat !== 4) begin miscompares++; $display("[TB] FAIL latency wc3: got %0d want 4", lat); end
      do_access(1'b0, 13'h0010, 16'h0000);
      vectors++; if (obs_rdata !== 16'h7777) begin miscompares++; $display("[TB] FAIL read 0010 before: got %h want 7777", obs_rdata); end
      tb_wr = 1'b1; tb_addr = 13'h0010; tb_wdata = 16'hBEEF;
      step();
      tb_wr = 1'b0;
      step();
      step();
      vectors++; if (obs_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy before reset: got %b want 1", obs_busy); end
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({obs_ready, obs_busy, obs_err, obs_rdata} !== 19'd0) begin
         miscompares++;
         $display("[TB] FAIL async reset in wait: got r%b b%b e%b d%h want all 0", obs_ready, obs_busy, obs_err, obs_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      vectors++; if (obs_busy !== 1'b0 || obs_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL pending after reset: got b%b r%b want b0 r0", obs_busy, obs_ready); end
      do_access(1'b0, 13'h0010, 16'h0000);
      vectors++; if (obs_rdata !== 16'h7777) begin miscompares++; $display("[TB] FAIL discarded write: got %h want 7777", obs_rdata); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      sel         = 0;
      lat         = 0;
      test_reset();
      test_write_read();
      test_collision();
      test_back_to_back();
      test_no_alias();
      test_addr_ignored();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
